shift_ctrl: RTL and testbench
=============================

SHIFT_CTRL -- requirements
Module: shift_ctrl

Interface
REQ-001 No parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op  input  2  shift operation: 00 SLL, 01 SRL, 10 SRA, 11 NOP.
REQ-006 amt_src  input  3  amount source selector.
REQ-007 amt_0  input  6  amount candidate 0 (instruction shamt field).
REQ-008 amt_2  input  6  amount candidate 2 (register-sourced amount).
REQ-009 amt_3  input  6  amount candidate 3 (memory-sourced amount).
REQ-010 data_in  input  32  operand to shift.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 done  output  1  one-cycle completion strobe.
REQ-013 data_out  output  32  working/result register.

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and DONE; the encoding is free.
REQ-015 In IDLE with start=1 at a rising edge, the block SHALL latch op and data_in into the working register, plus the resolved amount into a 6-bit counter.
REQ-016 Amount resolution SHALL be:
- amt_src 000 -> amt_0
- 001 -> constant 16
- 010 -> amt_2
- 011 -> amt_3
- any other value -> amt_0.
REQ-017 A resolved amount greater than 32 SHALL be clamped to 32 before loading the counter.
REQ-018 When op=11, the counter SHALL be loaded with 0 regardless of amt_src.
REQ-019 From IDLE on start, next state SHALL be SHIFT if the loaded count is nonzero, otherwise DONE.
REQ-020 In SHIFT, each rising edge SHALL shift the working register by exactly one bit and decrement the counter:
- SLL: shift left, zero fill
- SRL: shift right, zero fill
- SRA: shift right, replicate bit 31.
REQ-021 The SHIFT->DONE transition SHALL occur on the edge that performs the final shift, i.e. when the counter is 1 before that edge.
REQ-022 In DONE, done SHALL be 1 for exactly one cycle; next state SHALL be IDLE unconditionally.
REQ-023 Latency: for clamped amount N, done SHALL be high in the cycle after the (N+1)th rising edge, counting the start-sampling edge as the first; N=0 gives done one cycle after start.
REQ-024 start SHALL be ignored in SHIFT and DONE; no queuing.
REQ-025 Back-to-back operation: a start in the IDLE cycle immediately following DONE SHALL be accepted.
REQ-026 data_out SHALL equal the working register at all times:
- during SHIFT it shows intermediate values
- in DONE it holds the final result
- in IDLE it holds that result until the next accepted start.
REQ-027 Changes on op, amt_src, amt_* or data_in after the start edge SHALL NOT affect an operation in progress.
REQ-028 The result SHALL equal the single-step shift by the clamped amount, so that:
- SLL/SRL with amount 32 give 0
- SRA with amount 32 gives all bits equal to the original bit 31.

Reset
REQ-029 reset=1 SHALL, asynchronously and regardless of state, force:
- state to IDLE
- counter to 0
- working register (data_out) to 0
- busy to 0 and done to 0.
REQ-030 Reset asserted mid-SHIFT SHALL abort the operation with no done strobe; the first start after reset release SHALL behave as from a clean IDLE.

Verification
REQ-031 SLL by 16: op=00, amt_src=001, data_in=0x0000ABCD -> busy high for 17 cycles; done one cycle; data_out=0xABCD0000.
REQ-032 SRA clamp: op=10, amt_src=010, amt_2=40, data_in=0x80000001 -> clamp to 32; done after 33 edges; data_out=0xFFFFFFFF.
REQ-033 Zero and NOP cases:
- op=01, amt_src=000, amt_0=0, data_in=0x12345678 -> done one cycle after start; data_out=0x12345678
- op=11, amt_0=5 -> same result.
REQ-034 Ignored start and reserved selector: start pulsed during SHIFT (op=01, amt_src=011, amt_3=4, data_in=0xF0000000) -> no restart; data_out=0x0F000000; then amt_src=111, amt_0=1, op=00, data_in=0x1 in the next IDLE -> data_out=0x2.
REQ-035 Reset mid-operation: reset pulsed 3 cycles into a 20-bit shift -> data_out=0, busy=0, done never asserted; subsequent SLL by 1 of 0x1 -> 0x2.
REQ-036 Back-to-back: start held high continuously -> operations complete repeatedly, each start accepted only in IDLE; done pulses separated by N+2 cycles.

Source files
------------

// File: rtl/shift_ctrl.sv
// shift_ctrl: sequential barrel-shift replacement. The shifter moves the operand
// one bit per clock for a latched amount, then raises a one-cycle done strobe.
// A 6-bit down-counter holds the remaining shift count. The SHIFT->DONE move
// happens when the counter reaches its terminal count of 1.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; data_out holds the last result
// SHIFT | one single-bit shift per clock, counter decrements
// DONE  | result final, done strobe high for this one cycle
module shift_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [2:0]  amt_src,
    input  logic [5:0]  amt_0,
    input  logic [5:0]  amt_2,
    input  logic [5:0]  amt_3,
    input  logic [31:0] data_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] data_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    localparam logic [5:0] AMT_MAX = 6'd32;

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  cnt;
    logic [5:0]  cnt_nxt;
    logic [31:0] work;
    logic [31:0] work_nxt;
    logic [1:0]  op_q;
    logic [1:0]  op_q_nxt;

    logic [5:0]  amt_sel;
    logic [5:0]  amt_clamped;
    logic [5:0]  amt_load;
    logic [31:0] work_step;

    // Resolve the amount candidate from the selector. Reserved codes fall back to the shamt field.
    always_comb begin
        amt_sel = amt_0;
        case (amt_src)
            3'b000:  amt_sel = amt_0;
            3'b001:  amt_sel = 6'd16;
            3'b010:  amt_sel = amt_2;
            3'b011:  amt_sel = amt_3;
            default: amt_sel = amt_0;
        endcase
    end

    // Clamp to the word width. A NOP never shifts, so it always loads zero.
    always_comb begin
        amt_clamped = (amt_sel > AMT_MAX) ? AMT_MAX : amt_sel;
        amt_load    = (op == OP_NOP) ? 6'd0 : amt_clamped;
    end

    // One-bit step of the latched operation. Repeating this step 32 times fully clears or sign-fills the word.
    always_comb begin
        work_step = work;
        case (op_q)
            OP_SLL:  work_step = {work[30:0], 1'b0};
            OP_SRL:  work_step = {1'b0, work[31:1]};
            OP_SRA:  work_step = {work[31], work[31:1]};
            default: work_step = work;
        endcase
    end

    // Next-state and datapath update. Unused cases default to holding the current values.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        work_nxt  = work;
        op_q_nxt  = op_q;
        case (state)
            IDLE: begin
                if (start) begin
                    op_q_nxt  = op;
                    work_nxt  = data_in;
                    cnt_nxt   = amt_load;
                    state_nxt = (amt_load != 6'd0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                work_nxt = work_step;
                cnt_nxt  = cnt - 6'd1;
                if (cnt == 6'd1) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counter, operand and latched-op registers. Reset clears everything asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 6'd0;
            work  <= 32'd0;
            op_q  <= OP_SLL;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            work  <= work_nxt;
            op_q  <= op_q_nxt;
        end
    end

    // Outputs are decoded directly from registered state, so they carry no glitches from the inputs.
    always_comb begin
        busy     = (state != IDLE);
        done     = (state == DONE);
        data_out = work;
    end

endmodule

// File: tb/tb_shift_ctrl.sv
// Self-checking bench for shift_ctrl. It checks directed vectors from a table,
// then randomized operations against a reference model of the shift rules,
// then hand-written reset-abort and back-to-back sequences.
module tb_shift_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [2:0]  amt_src;
    logic [5:0]  amt_0;
    logic [5:0]  amt_2;
    logic [5:0]  amt_3;
    logic [31:0] data_in;
    logic        busy;
    logic        done;
    logic [31:0] data_out;

    int n_cmp = 0;
    int n_bad = 0;

    shift_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .amt_src  (amt_src),
        .amt_0    (amt_0),
        .amt_2    (amt_2),
        .amt_3    (amt_3),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  o;
        logic [2:0]  s;
        logic [5:0]  a0;
        logic [5:0]  a2;
        logic [5:0]  a3;
        logic [31:0] d;
        int          n;
        logic [31:0] res;
        bit          noisy;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Reference: the amount chosen by the selector, limited to 32, and forced to zero for a NOP
    function automatic int ref_amt(input logic [1:0] o, input logic [2:0] s,
                                   input logic [5:0] a0, input logic [5:0] a2, input logic [5:0] a3);
        int a;
        case (s)
            3'd0:    a = a0;
            3'd1:    a = 16;
            3'd2:    a = a2;
            3'd3:    a = a3;
            default: a = a0;
        endcase
        if (a > 32) a = 32;
        if (o == 2'b11) a = 0;
        return a;
    endfunction

    // Reference: a single shift of the whole word by the full amount
    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d, input int a);
        logic signed [31:0] sd;
        sd = d;
        case (o)
            2'b00:   return (a >= 32) ? 32'd0 : (d << a);
            2'b01:   return (a >= 32) ? 32'd0 : (d >> a);
            2'b10:   return (a >= 32) ? {32{d[31]}} : 32'(sd >>> a);
            default: return d;
        endcase
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [2:0] s, input logic [5:0] a0,
                          input logic [5:0] a2, input logic [5:0] a3, input logic [31:0] d,
                          input int exp_n, input logic [31:0] exp_res, input bit noisy,
                          input string tag);
        int k;
        int busy_cnt;
        bit seen;
        @(negedge clk);
        op = o; amt_src = s; amt_0 = a0; amt_2 = a2; amt_3 = a3; data_in = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (noisy) begin
            op      = 2'($urandom);
            amt_src = 3'($urandom);
            amt_0   = 6'($urandom);
            amt_2   = 6'($urandom);
            amt_3   = 6'($urandom);
            data_in = $urandom;
        end
        k = 0;
        busy_cnt = 0;
        seen = 1'b0;
        while (!seen && k < 80) begin
            @(negedge clk);
            k++;
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
            else if (noisy && k <= exp_n) start = 1'($urandom);
            else start = 1'b0;
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(k), 32'(exp_n + 1));
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_n + 1));
        check({tag, " result"}, data_out, exp_res);
        @(negedge clk);
        check({tag, " idle busy/done"}, {30'd0, busy, done}, 32'd0);
        check({tag, " idle hold"}, data_out, exp_res);
    endtask

    initial begin
        vecs[0] = '{2'b00, 3'b001, 6'd0,  6'd0,  6'd0,  32'h0000ABCD, 16, 32'hABCD0000, 1'b0};
        vecs[1] = '{2'b10, 3'b010, 6'd0,  6'd40, 6'd0,  32'h80000001, 32, 32'hFFFFFFFF, 1'b0};
        vecs[2] = '{2'b01, 3'b000, 6'd0,  6'd0,  6'd0,  32'h12345678, 0,  32'h12345678, 1'b0};
        vecs[3] = '{2'b11, 3'b000, 6'd5,  6'd0,  6'd0,  32'h12345678, 0,  32'h12345678, 1'b0};
        vecs[4] = '{2'b01, 3'b011, 6'd0,  6'd0,  6'd4,  32'hF0000000, 4,  32'h0F000000, 1'b1};
        vecs[5] = '{2'b00, 3'b111, 6'd1,  6'd0,  6'd0,  32'h00000001, 1,  32'h00000002, 1'b0};
        vecs[6] = '{2'b01, 3'b001, 6'd9,  6'd0,  6'd0,  32'h80000000, 16, 32'h00008000, 1'b1};
        vecs[7] = '{2'b10, 3'b011, 6'd0,  6'd0,  6'd33, 32'h7FFFFFFF, 32, 32'h00000000, 1'b1};
        vecs[8] = '{2'b00, 3'b000, 6'd32, 6'd0,  6'd0,  32'hFFFFFFFF, 32, 32'h00000000, 1'b0};
        vecs[9] = '{2'b10, 3'b010, 6'd0,  6'd31, 6'd0,  32'h80000000, 31, 32'hFFFFFFFF, 1'b1};

        reset = 1'b1; start = 1'b0; op = 2'b00; amt_src = 3'b000;
        amt_0 = 6'd0; amt_2 = 6'd0; amt_3 = 6'd0; data_in = 32'd0;
        #12;
        check("reset outputs", {busy, done, data_out[29:0]}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].o, vecs[i].s, vecs[i].a0, vecs[i].a2, vecs[i].a3, vecs[i].d,
                   vecs[i].n, vecs[i].res, vecs[i].noisy, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  o;
            logic [2:0]  s;
            logic [5:0]  a0, a2, a3;
            logic [31:0] d;
            int          n;
            o  = 2'($urandom_range(0, 3));
            s  = 3'($urandom_range(0, 7));
            a0 = 6'($urandom_range(0, 63));
            a2 = 6'($urandom_range(0, 63));
            a3 = 6'($urandom_range(0, 63));
            d  = $urandom;
            n  = ref_amt(o, s, a0, a2, a3);
            run_op(o, s, a0, a2, a3, d, n, ref_shift(o, d, n), 1'b1, $sformatf("rnd%0d", i));
        end

        // Reset during a 20-bit shift: the operation is aborted and no done strobe appears
        begin
            bit saw_done;
            saw_done = 1'b0;
            @(negedge clk);
            op = 2'b00; amt_src = 3'b000; amt_0 = 6'd20; data_in = 32'h1; start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (3) @(posedge clk);
            #2;
            check("pre-reset shifting", {31'd0, busy}, 32'd1);
            reset = 1'b1;
            #1;
            check("reset data_out", data_out, 32'd0);
            check("reset busy/done", {30'd0, busy, done}, 32'd0);
            @(negedge clk);
            reset = 1'b0;
            for (int c = 0; c < 25; c++) begin
                @(negedge clk);
                if (done || busy) saw_done = 1'b1;
            end
            check("no activity after reset", {31'd0, saw_done}, 32'd0);
            run_op(2'b00, 3'b000, 6'd1, 6'd0, 6'd0, 32'h1, 1, 32'h2, 1'b0, "post-reset");
        end

        // start held high: each pulse is accepted in IDLE, so done repeats every N+2 cycles
        begin
            int cyc;
            int last;
            int pulses;
            cyc = 0; last = -1; pulses = 0;
            @(negedge clk);
            op = 2'b00; amt_src = 3'b000; amt_0 = 6'd3; data_in = 32'h1; start = 1'b1;
            while (pulses < 4 && cyc < 200) begin
                @(negedge clk);
                cyc++;
                if (done) begin
                    if (last >= 0) check("b2b interval", 32'(cyc - last), 32'd5);
                    check("b2b result", data_out, 32'h8);
                    last = cyc;
                    pulses++;
                end
            end
            start = 1'b0;
            check("b2b pulse count", 32'(pulses), 32'd4);
            repeat (8) @(negedge clk);
            check("b2b settles idle", {30'd0, busy, done}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
